pipe_e_reg: RTL and testbench

PIPE_E_REG -- requirements
Module: pipe_e_reg

---
 rtl/pipe_e_reg.sv | 154 +++++++++++++++
 tb/tb_pipe_e_reg.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_e_reg.sv
// Execute-stage pipeline register: decode bundle in, execute bundle out.
// Optional PIPE_E_REG_PERF_EN adds saturating stall/bubble counters.
module pipe_e_reg #(
  parameter int unsigned WORD_W  = 64,
  parameter int unsigned FIELD_W = 4,
  parameter logic [FIELD_W-1:0] NOP_ICODE = 4'h1,
  parameter logic [FIELD_W-1:0] RNONE     = 4'hF,
  parameter logic [FIELD_W-1:0] BUB_STAT  = 4'h1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FIELD_W-1:0] d_icode,
  input  logic [FIELD_W-1:0] d_ifun,
  input  logic [FIELD_W-1:0] d_stat,
  input  logic [WORD_W-1:0]  d_valA,
  input  logic [WORD_W-1:0]  d_valB,
  input  logic [WORD_W-1:0]  d_valC,
  input  logic [FIELD_W-1:0] d_dstE,
  input  logic [FIELD_W-1:0] d_dstM,
  input  logic [FIELD_W-1:0] d_srcA,
  input  logic [FIELD_W-1:0] d_srcB,
  input  logic               E_stall,
  input  logic               E_bubble,
  output logic [FIELD_W-1:0] E_icode,
  output logic [FIELD_W-1:0] E_ifun,
  output logic [FIELD_W-1:0] E_stat,
  output logic [FIELD_W-1:0] E_dstE,
  output logic [FIELD_W-1:0] E_dstM,
  output logic [FIELD_W-1:0] E_srcA,
  output logic [FIELD_W-1:0] E_srcB,
  output logic [WORD_W-1:0]  E_valA,
  output logic [WORD_W-1:0]  E_valB,
  output logic [WORD_W-1:0]  E_valC,
  output logic               E_valid,
`ifdef PIPE_E_REG_PERF_EN
  output logic [15:0]        perf_stall_cnt,
  output logic [15:0]        perf_bubble_cnt,
`endif
  output logic               E_ctl_err
);

  typedef struct packed {
    logic [FIELD_W-1:0] icode;
    logic [FIELD_W-1:0] ifun;
    logic [FIELD_W-1:0] stat;
    logic [WORD_W-1:0]  valA;
    logic [WORD_W-1:0]  valB;
    logic [WORD_W-1:0]  valC;
    logic [FIELD_W-1:0] dstE;
    logic [FIELD_W-1:0] dstM;
    logic [FIELD_W-1:0] srcA;
    logic [FIELD_W-1:0] srcB;
    logic               valid;
  } e_bundle_t;

  e_bundle_t e_q, e_d;
  e_bundle_t bub_v, load_v;
  logic      err_q, err_d;

  // One-hot decode of the edge action, priority already resolved.
  logic do_rst, do_bub, do_stall, do_load;

  assign do_rst   = reset;
  assign do_bub   = !reset && E_bubble;
  assign do_stall = !reset && !E_bubble && E_stall;
  assign do_load  = !reset && !E_bubble && !E_stall;

  always_comb begin
    bub_v       = '0;
    bub_v.icode = NOP_ICODE;
    bub_v.ifun  = '0;
    bub_v.stat  = BUB_STAT;
    bub_v.dstE  = RNONE;
    bub_v.dstM  = RNONE;
    bub_v.srcA  = RNONE;
    bub_v.srcB  = RNONE;
    bub_v.valid = 1'b0;
  end

  always_comb begin
    load_v.icode = d_icode;
    load_v.ifun  = d_ifun;
    load_v.stat  = d_stat;
    load_v.valA  = d_valA;
    load_v.valB  = d_valB;
    load_v.valC  = d_valC;
    load_v.dstE  = d_dstE;
    load_v.dstM  = d_dstM;
    load_v.srcA  = d_srcA;
    load_v.srcB  = d_srcB;
    load_v.valid = 1'b1;
  end

  always_comb begin
    e_d   = e_q;
    err_d = 1'b0;
    unique case (1'b1)
      do_rst:   e_d = bub_v;
      do_bub: begin
        e_d   = bub_v;
        err_d = E_stall;
      end
      do_stall: e_d = e_q;
      do_load:  e_d = load_v;
      default:  e_d = e_q;
    endcase
  end

  always_ff @(posedge clk) begin
    e_q   <= e_d;
    err_q <= err_d;
  end

  assign E_icode   = e_q.icode;
  assign E_ifun    = e_q.ifun;
  assign E_stat    = e_q.stat;
  assign E_valA    = e_q.valA;
  assign E_valB    = e_q.valB;
  assign E_valC    = e_q.valC;
  assign E_dstE    = e_q.dstE;
  assign E_dstM    = e_q.dstM;
  assign E_srcA    = e_q.srcA;
  assign E_srcB    = e_q.srcB;
  assign E_valid   = e_q.valid;
  assign E_ctl_err = err_q;

`ifdef PIPE_E_REG_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] bub_cnt_q, bub_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    bub_cnt_d   = bub_cnt_q;
    if (do_rst) begin
      stall_cnt_d = '0;
      bub_cnt_d   = '0;
    end else begin
      if (do_stall && stall_cnt_q != 16'hFFFF)
        stall_cnt_d = stall_cnt_q + 16'd1;
      if (do_bub && bub_cnt_q != 16'hFFFF)
        bub_cnt_d = bub_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    stall_cnt_q <= stall_cnt_d;
    bub_cnt_q   <= bub_cnt_d;
  end

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_bubble_cnt = bub_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_e_reg.sv
// Randomized bench for pipe_e_reg with a behavioural model of the register.
// Define PIPE_E_REG_PERF_EN to also exercise the perf counters.
module tb_pipe_e_reg;

  localparam int W = 64;
  localparam int F = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [F-1:0] d_icode, d_ifun, d_stat;
  logic [W-1:0] d_valA, d_valB, d_valC;
  logic [F-1:0] d_dstE, d_dstM, d_srcA, d_srcB;
  logic         E_stall, E_bubble;
  logic [F-1:0] E_icode, E_ifun, E_stat;
  logic [F-1:0] E_dstE, E_dstM, E_srcA, E_srcB;
  logic [W-1:0] E_valA, E_valB, E_valC;
  logic         E_valid, E_ctl_err;
`ifdef PIPE_E_REG_PERF_EN
  logic [15:0]  perf_stall_cnt, perf_bubble_cnt;
`endif

  pipe_e_reg dut (
    .clk(clk), .reset(reset),
    .d_icode(d_icode), .d_ifun(d_ifun), .d_stat(d_stat),
    .d_valA(d_valA), .d_valB(d_valB), .d_valC(d_valC),
    .d_dstE(d_dstE), .d_dstM(d_dstM),
    .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_stall(E_stall), .E_bubble(E_bubble),
    .E_icode(E_icode), .E_ifun(E_ifun), .E_stat(E_stat),
    .E_dstE(E_dstE), .E_dstM(E_dstM),
    .E_srcA(E_srcA), .E_srcB(E_srcB),
    .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
    .E_valid(E_valid),
`ifdef PIPE_E_REG_PERF_EN
    .perf_stall_cnt(perf_stall_cnt),
    .perf_bubble_cnt(perf_bubble_cnt),
`endif
    .E_ctl_err(E_ctl_err)
  );

  int checks = 0;
  int errors = 0;

  // Model: the instruction currently held (or a NOP), plus flags/counters.
  localparam int VW = 7*F + 3*W + 2;
  logic [F-1:0] m_icode, m_ifun, m_stat, m_dstE, m_dstM, m_srcA, m_srcB;
  logic [W-1:0] m_valA, m_valB, m_valC;
  logic         m_valid, m_err;
  int           m_scnt, m_bcnt;

  function automatic logic [VW-1:0] obs();
    return {E_icode, E_ifun, E_stat, E_dstE, E_dstM, E_srcA, E_srcB,
            E_valA, E_valB, E_valC, E_valid, E_ctl_err};
  endfunction

  function automatic logic [VW-1:0] expv();
    return {m_icode, m_ifun, m_stat, m_dstE, m_dstM, m_srcA, m_srcB,
            m_valA, m_valB, m_valC, m_valid, m_err};
  endfunction

  task automatic model_nop();
    m_icode = 4'h1; m_ifun = 4'h0; m_stat = 4'h1;
    m_dstE = 4'hF; m_dstM = 4'hF; m_srcA = 4'hF; m_srcB = 4'hF;
    m_valA = '0; m_valB = '0; m_valC = '0; m_valid = 1'b0;
  endtask

  // Advance one clock: update the model from the inputs seen at the edge.
  task automatic tick();
    if (reset) begin
      model_nop(); m_err = 0; m_scnt = 0; m_bcnt = 0;
    end else if (E_bubble) begin
      model_nop(); m_err = E_stall;
      if (m_bcnt < 65535) m_bcnt++;
    end else if (E_stall) begin
      m_err = 0;
      if (m_scnt < 65535) m_scnt++;
    end else begin
      m_icode = d_icode; m_ifun = d_ifun; m_stat = d_stat;
      m_dstE = d_dstE; m_dstM = d_dstM; m_srcA = d_srcA; m_srcB = d_srcB;
      m_valA = d_valA; m_valB = d_valB; m_valC = d_valC;
      m_valid = 1'b1; m_err = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_d();
    d_icode = F'($urandom); d_ifun = F'($urandom); d_stat = F'($urandom);
    d_dstE = F'($urandom); d_dstM = F'($urandom);
    d_srcA = F'($urandom); d_srcB = F'($urandom);
    d_valA = {$urandom, $urandom};
    d_valB = {$urandom, $urandom};
    d_valC = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    reset = 1; E_stall = 0; E_bubble = 0;
    for (int i = 0; i < 2; i++) begin rand_d(); tick(); end
    checks++;
    if (obs() !== expv()) begin
      errors++;
      $display("FAIL reset_bundle got=%h exp=%h", obs(), expv());
    end
    checks++;
    if (E_icode !== 4'h1 || E_dstE !== 4'hF || E_valA !== '0 || E_valid !== 0) begin
      errors++;
      $display("FAIL reset_const icode=%h dstE=%h valA=%h valid=%b (want 1 F 0 0)",
               E_icode, E_dstE, E_valA, E_valid);
    end
`ifdef PIPE_E_REG_PERF_EN
    checks++;
    if (perf_stall_cnt !== 0 || perf_bubble_cnt !== 0) begin
      errors++;
      $display("FAIL reset_cnt got=%h/%h exp=0/0", perf_stall_cnt, perf_bubble_cnt);
    end
`endif
    reset = 0;
  endtask

  task automatic test_load();
    rand_d();
    d_icode = 4'h6; d_ifun = 4'h0; d_valA = 64'h5; d_valB = 64'h7; d_dstE = 4'h3;
    tick();
    checks++;
    if (E_icode !== 4'h6 || E_ifun !== 4'h0 || E_valA !== 64'h5 ||
        E_valB !== 64'h7 || E_dstE !== 4'h3 || E_valid !== 1'b1) begin
      errors++;
      $display("FAIL load_const icode=%h valA=%h valB=%h dstE=%h valid=%b",
               E_icode, E_valA, E_valB, E_dstE, E_valid);
    end
    checks++;
    if (obs() !== expv()) begin
      errors++;
      $display("FAIL load_bundle got=%h exp=%h", obs(), expv());
    end
  endtask

  task automatic test_stall();
    rand_d(); d_icode = 4'h3; tick();
    E_stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_d(); d_icode = 4'h5; tick();
      checks++;
      if (E_icode !== 4'h3 || obs() !== expv()) begin
        errors++;
        $display("FAIL stall_hold[%0d] icode=%h got=%h exp=%h", i, E_icode, obs(), expv());
      end
    end
    E_stall = 0; tick();
    checks++;
    if (E_icode !== 4'h5 || E_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_release icode=%h valid=%b exp=5 1", E_icode, E_valid);
    end
  endtask

  task automatic test_conflict();
    rand_d(); tick();
    E_stall = 1; E_bubble = 1; rand_d(); tick();
    checks++;
    if (E_icode !== 4'h1 || E_dstE !== 4'hF || E_valid !== 0 || E_ctl_err !== 1) begin
      errors++;
      $display("FAIL conflict icode=%h dstE=%h valid=%b err=%b exp=1 F 0 1",
               E_icode, E_dstE, E_valid, E_ctl_err);
    end
    E_stall = 0; E_bubble = 0; rand_d(); tick();
    checks++;
    if (E_ctl_err !== 0 || obs() !== expv()) begin
      errors++;
      $display("FAIL conflict_after err=%b got=%h exp=%h", E_ctl_err, obs(), expv());
    end
    // bubble alone must not flag an error, and zeroes the operands
    E_bubble = 1; tick();
    checks++;
    if (E_ctl_err !== 0 || E_valB !== '0 || obs() !== expv()) begin
      errors++;
      $display("FAIL bubble_only err=%b valB=%h got=%h exp=%h",
               E_ctl_err, E_valB, obs(), expv());
    end
    E_bubble = 0;
  endtask

  task automatic test_reset_mid_stall();
    rand_d(); d_icode = 4'h6; tick();
    E_stall = 1; rand_d(); tick(); tick();
    reset = 1; tick();
    checks++;
    if (E_icode !== 4'h1 || E_valid !== 0 || obs() !== expv()) begin
      errors++;
      $display("FAIL reset_mid_stall got=%h exp=%h", obs(), expv());
    end
`ifdef PIPE_E_REG_PERF_EN
    checks++;
    if (perf_stall_cnt !== 0 || perf_bubble_cnt !== 0) begin
      errors++;
      $display("FAIL reset_mid_stall_cnt got=%h/%h exp=0/0",
               perf_stall_cnt, perf_bubble_cnt);
    end
`endif
    reset = 0; E_stall = 0;
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      rand_d();
      reset    = ($urandom_range(0, 29) == 0);
      E_bubble = ($urandom_range(0, 4) == 0);
      E_stall  = ($urandom_range(0, 2) == 0);
      tick();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        if (bad++ < 5)
          $display("FAIL random[%0d] got=%h exp=%h", i, obs(), expv());
      end
`ifdef PIPE_E_REG_PERF_EN
      checks++;
      if (perf_stall_cnt !== 16'(m_scnt) || perf_bubble_cnt !== 16'(m_bcnt)) begin
        errors++;
        if (bad++ < 5)
          $display("FAIL random_cnt[%0d] got=%h/%h exp=%h/%h", i,
                   perf_stall_cnt, perf_bubble_cnt, 16'(m_scnt), 16'(m_bcnt));
      end
`endif
    end
    reset = 0; E_bubble = 0; E_stall = 0;
  endtask

`ifdef PIPE_E_REG_PERF_EN
  task automatic test_perf();
    int b0;
    reset = 1; tick(); reset = 0;
    E_bubble = 1; tick(); tick(); E_bubble = 0;
    b0 = m_bcnt;
    E_stall = 1;
    for (int i = 0; i < 70000; i++) tick();
    E_stall = 0;
    checks++;
    if (perf_stall_cnt !== 16'hFFFF || perf_bubble_cnt !== 16'(b0)) begin
      errors++;
      $display("FAIL perf_sat got=%h/%h exp=ffff/%h",
               perf_stall_cnt, perf_bubble_cnt, 16'(b0));
    end
  endtask
`endif

  initial begin
    reset = 1; E_stall = 0; E_bubble = 0;
    rand_d();
    m_scnt = 0; m_bcnt = 0; m_err = 0; model_nop();
    #1;
    test_reset();
    test_load();
    test_stall();
    test_conflict();
    test_reset_mid_stall();
    test_random();
`ifdef PIPE_E_REG_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
